// File: rtl/step_sched_pkg.sv
// Shared types and constants for the step scheduler.
package step_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // Bit position of each source in the request/grant vectors matches its value.
    typedef enum logic [1:0] {
        SRC_MAN  = 2'd0,
        SRC_AUX  = 2'd1,
        SRC_AUTO = 2'd2
    } src_e;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: the source granted last has the lowest priority.
module rr_arb3
    import step_sched_pkg::*;
(
    input  logic [2:0] req_i,
    input  src_e       last_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        case (last_i)
            SRC_MAN: begin
                if (req_i[1])      gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
            end
            SRC_AUX: begin
                if (req_i[2])      gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
            end
            default: begin
                if (req_i[0])      gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/step_scheduler.sv
// Arbitrates manual, auxiliary and optional auto-sweep requests into one-cycle step commands.
// Define AUTO_SWEEP_EN to add the internal auto-sweep source as a third requester.
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned AUTO_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             man_req,
    input  logic [1:0]       man_step,
    input  logic             aux_req,
    input  logic [1:0]       aux_step,
    input  logic             pause,
    output logic             man_gnt,
    output logic             aux_gnt,
    output logic             step_en,
    output logic [1:0]       step_amt,
    output logic             busy,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [3:0] HOLD_LOAD = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    state_e           state_q;
    src_e             last_q;
    logic [3:0]       hold_q;
    logic             man_gnt_q;
    logic             aux_gnt_q;
    logic             step_en_q;
    logic [1:0]       step_amt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       req_vec;
    logic [2:0]       gnt_vec;
    logic             arb_go;
    src_e             win_d;
    logic [1:0]       win_step_d;

`ifdef AUTO_SWEEP_EN
    localparam src_e LAST_INIT = SRC_AUTO;

    logic [15:0] div_q;
    logic        auto_pending_q;
    logic        div_wrap;

    assign div_wrap = !pause && (div_q == 16'(AUTO_DIV - 1));
    assign req_vec  = {auto_pending_q, aux_req, man_req};

    // A wrap re-arms the sticky request even on the edge its previous one is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q          <= '0;
            auto_pending_q <= 1'b0;
        end else begin
            if (!pause) div_q <= div_wrap ? 16'd0 : div_q + 16'd1;
            if (div_wrap)                  auto_pending_q <= 1'b1;
            else if (arb_go && gnt_vec[2]) auto_pending_q <= 1'b0;
        end
    end
`else
    localparam src_e LAST_INIT = SRC_AUX;

    logic unused_auto_div;

    assign unused_auto_div = ^32'(AUTO_DIV);
    assign req_vec         = {1'b0, aux_req, man_req};
`endif

    rr_arb3 u_arb (
        .req_i  (req_vec),
        .last_i (last_q),
        .gnt_o  (gnt_vec)
    );

    assign arb_go = (state_q == IDLE) && !pause && (gnt_vec != 3'b000);

    always_comb begin
        win_d      = SRC_AUTO;
        win_step_d = 2'd1;
        if (gnt_vec[0]) begin
            win_d      = SRC_MAN;
            win_step_d = man_step;
        end else if (gnt_vec[1]) begin
            win_d      = SRC_AUX;
            win_step_d = aux_step;
        end
    end

    assign cnt_d = (step_en_q && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    // Grant and step outputs are registered so they appear exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= LAST_INIT;
            hold_q     <= 4'd0;
            man_gnt_q  <= 1'b0;
            aux_gnt_q  <= 1'b0;
            step_en_q  <= 1'b0;
            step_amt_q <= 2'd0;
            cnt_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            man_gnt_q  <= 1'b0;
            aux_gnt_q  <= 1'b0;
            step_en_q  <= 1'b0;
            step_amt_q <= 2'd0;
            case (state_q)
                IDLE: begin
                    if (arb_go) begin
                        state_q    <= ISSUE;
                        last_q     <= win_d;
                        man_gnt_q  <= gnt_vec[0];
                        aux_gnt_q  <= gnt_vec[1];
                        step_en_q  <= (win_step_d != 2'd0);
                        step_amt_q <= win_step_d;
                    end
                end
                ISSUE: begin
                    if (HOLD_CYC == 0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= SETTLE;
                        hold_q  <= HOLD_LOAD;
                    end
                end
                SETTLE: begin
                    if (hold_q == 4'd0) state_q <= IDLE;
                    else                hold_q  <= hold_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign man_gnt  = man_gnt_q;
    assign aux_gnt  = aux_gnt_q;
    assign step_en  = step_en_q;
    assign step_amt = step_amt_q;
    assign busy     = (state_q != IDLE);
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Randomized scoreboard bench for step_scheduler against a latency-rule reference model.
// Honours AUTO_SWEEP_EN the same way as the design.
module tb_step_scheduler;

    localparam int HOLD = 2;
    localparam int ADIV = 8;

    logic       clk;
    logic       rst;
    logic       man_req;
    logic [1:0] man_step;
    logic       aux_req;
    logic [1:0] aux_step;
    logic       pause;
    logic       man_gnt;
    logic       aux_gnt;
    logic       step_en;
    logic [1:0] step_amt;
    logic       busy;
    logic [7:0] step_cnt;

    typedef struct {
        int cyc;
        int src;
        int step;
    } issue_t;

    issue_t sb[$];

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    bit  checking = 0;

    int  lastSrc;
    int  freeAt = 0;
    int  busyUntil = -1;
    int  expCnt = 0;
    bit  pendingInc = 0;
    int  autoDiv = 0;
    bit  autoPend = 0;

`ifdef AUTO_SWEEP_EN
    localparam int LAST_INIT = 2;
`else
    localparam int LAST_INIT = 1;
`endif

    step_scheduler #(
        .HOLD_CYC (HOLD),
        .AUTO_DIV (ADIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .man_req  (man_req),
        .man_step (man_step),
        .aux_req  (aux_req),
        .aux_step (aux_step),
        .pause    (pause),
        .man_gnt  (man_gnt),
        .aux_gnt  (aux_gnt),
        .step_en  (step_en),
        .step_amt (step_amt),
        .busy     (busy),
        .step_cnt (step_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Round-robin rule: scan sources starting just after the one granted last.
    function automatic int pick(input int last, input bit rm, input bit ra, input bit rx);
        for (int k = 1; k <= 3; k++) begin
            int s;
            bit r;
            s = (last + k) % 3;
            r = (s == 0) ? rm : (s == 1) ? ra : rx;
            if (r) return s;
        end
        return -1;
    endfunction

    // Reference model: an idle scheduler arbitrates at edge n, issues in cycle n+1,
    // is busy through n+1+HOLD and may arbitrate again at edge n+2+HOLD.
    initial begin
        lastSrc = LAST_INIT;
        forever begin
            @(posedge clk);
            if (rst) begin
                lastSrc    = LAST_INIT;
                freeAt     = cyc + 1;
                busyUntil  = -1;
                expCnt     = 0;
                pendingInc = 0;
                autoDiv    = 0;
                autoPend   = 0;
            end else begin
                int win;
                bit wrap;
                if (pendingInc && expCnt < 255) expCnt++;
                pendingInc = 0;
                win = -1;
                if (cyc >= freeAt && !pause) win = pick(lastSrc, man_req, aux_req, autoPend);
                if (win >= 0) begin
                    issue_t e;
                    e.cyc  = cyc + 1;
                    e.src  = win;
                    e.step = (win == 0) ? int'(man_step) : (win == 1) ? int'(aux_step) : 1;
                    sb.push_back(e);
                    freeAt     = cyc + 2 + HOLD;
                    busyUntil  = cyc + 1 + HOLD;
                    lastSrc    = win;
                    pendingInc = (e.step != 0);
                end
`ifdef AUTO_SWEEP_EN
                wrap = !pause && (autoDiv == ADIV - 1);
                if (!pause) autoDiv = wrap ? 0 : autoDiv + 1;
                if (wrap) autoPend = 1;
                else if (win == 2) autoPend = 0;
`else
                wrap = 0;
`endif
            end
            cyc++;
        end
    end

    // Monitor: pops the expected issue whenever the DUT presents one, else expects quiet outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL missedIssue cycle %0d: got no issue, expected src %0d in cycle %0d",
                             cyc, sb[0].src, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    issue_t e;
                    e = sb.pop_front();
                    checkOutput("manGnt", 32'(man_gnt), (e.src == 0) ? 1 : 0);
                    checkOutput("auxGnt", 32'(aux_gnt), (e.src == 1) ? 1 : 0);
                    checkOutput("stepEn", 32'(step_en), (e.step != 0) ? 1 : 0);
                    checkOutput("stepAmt", 32'(step_amt), e.step);
                end else begin
                    checkOutput("manGntQuiet", 32'(man_gnt), 0);
                    checkOutput("auxGntQuiet", 32'(aux_gnt), 0);
                    checkOutput("stepEnQuiet", 32'(step_en), 0);
                    checkOutput("stepAmtQuiet", 32'(step_amt), 0);
                end
                checkOutput("busy", 32'(busy), (cyc <= busyUntil) ? 1 : 0);
                checkOutput("stepCnt", 32'(step_cnt), expCnt);
            end
        end
    end

    // One negedge of stimulus; requesters hold req until their grant is seen.
    task automatic applyStimulus(input bit allowReset, input bit sparse);
        if (rst) begin
            rst = 1'b0;
        end else if (allowReset && busy && !step_en && !man_gnt && !aux_gnt &&
                     $urandom_range(0, 15) == 0) begin
            rst = 1'b1;
        end
        if (man_req && man_gnt) begin
            man_req = 1'b0;
        end else if (!man_req && (!sparse || $urandom_range(0, 3) == 0)) begin
            man_req  = 1'b1;
            man_step = sparse ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
        end
        if (aux_req && aux_gnt) begin
            aux_req = 1'b0;
        end else if (!aux_req && (!sparse || $urandom_range(0, 3) == 0)) begin
            aux_req  = 1'b1;
            aux_step = sparse ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
        end
        if (!sparse) pause = 1'b0;
        else if ($urandom_range(0, 7) == 0) pause = ~pause;
    endtask

    initial begin
        rst      = 1'b1;
        man_req  = 1'b0;
        man_step = 2'd0;
        aux_req  = 1'b0;
        aux_step = 2'd0;
        pause    = 1'b0;
        @(posedge clk);
        #2 checking = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sparse phase: zero steps, pauses and mid-SETTLE resets.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1);
        end
        // Dense phase: both requesters always pending with nonzero steps to saturate step_cnt.
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0);
        end
        @(negedge clk);
        man_req = 1'b0;
        aux_req = 1'b0;
        pause   = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(sb.size()), 0);
        checkOutput("stepCntSaturated", 32'(step_cnt), 255);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_scheduler.md
STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter HOLD_CYC, default 2: settle cycles after each issued step; legal range 0..15.
REQ-002 Parameter AUTO_DIV, default 8: clock cycles between auto-sweep requests; legal range 2..65535.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 man_req  in  1  manual requester valid; held high until man_gnt.
REQ-006 man_step  in  2  manual step magnitude 0..3; stable while man_req is high.
REQ-007 aux_req  in  1  auxiliary requester valid; held high until aux_gnt.
REQ-008 aux_step  in  2  auxiliary step magnitude 0..3; stable while aux_req is high.
REQ-009 pause  in  1  when high, blocks new arbitration.
REQ-010 man_gnt  out  1  one-cycle grant pulse to the manual requester.
REQ-011 aux_gnt  out  1  one-cycle grant pulse to the auxiliary requester.
REQ-012 step_en  out  1  one-cycle step command to the 4-bit level counter datapath.
REQ-013 step_amt  out  2  step magnitude, valid while step_en is high, else 0.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 step_cnt  out  8  count of issued step_en pulses, saturating at 255.

Function
REQ-016 FSM states are IDLE, ISSUE and SETTLE; it SHALL be encoded as registered state.
REQ-017 IDLE: the FSM stays in IDLE when pause is high or no request is pending; otherwise it latches the winner and its step and moves to ISSUE.
REQ-018 Arbitration SHALL be round-robin: the most recently granted source has the lowest priority next; after reset, man has highest priority, then aux, then auto.
REQ-019 ISSUE lasts exactly one cycle: the winner's gnt is high, and step_en is high with step_amt equal to the latched step.
REQ-020 A latched step of 0 SHALL still produce gnt; step_en stays low, step_amt is 0 and step_cnt does not change.
REQ-021 After ISSUE the FSM SHALL enter SETTLE for HOLD_CYC cycles and then return to IDLE; if HOLD_CYC is 0 it goes straight from ISSUE to IDLE.
REQ-022 Latency: a request seen in IDLE at edge N gives gnt/step_en in the cycle after N; with no pause and no competitor, the next arbitration is at edge N+2+HOLD_CYC.
REQ-023 Requests are ignored while in ISSUE or SETTLE; a request still high when IDLE is reached is arbitrated normally.
REQ-024 Pause is sampled only in IDLE; a step already in ISSUE or SETTLE SHALL complete.
REQ-025 Simultaneous requests produce exactly one grant per ISSUE; at most one gnt is high in any cycle.
REQ-026 step_cnt increments on each cycle where step_en is high and holds at 255.

Reset
REQ-027 While rst is high at a clock edge, on the next cycle: state is IDLE; man_gnt, aux_gnt, step_en, busy and step_amt are 0; step_cnt is 0; the round-robin pointer is at its initial value; the auto divider and auto_pending are 0.
REQ-028 Reset asserted mid-ISSUE or mid-SETTLE SHALL abort the operation with no further step_en.

Configuration
REQ-029 With macro AUTO_SWEEP_EN defined, an internal divider counts the cycles where pause is low and wraps at AUTO_DIV-1.
REQ-030 With AUTO_SWEEP_EN defined, each wrap sets a sticky internal auto_pending request with step 1; auto_pending clears on its grant and joins round-robin as the third source.
REQ-031 With AUTO_SWEEP_EN undefined, the divider and auto_pending are absent, and arbitration is two-way round-robin between man and aux.

Structure
REQ-032 A shared package step_sched_pkg SHALL hold the FSM state enum, the source-index enum (SRC_MAN, SRC_AUX, SRC_AUTO) and the step_cnt width constant.
REQ-033 Round-robin arbitration SHALL be a sub-module rr_arb3 (request vector, pointer in; one-hot grant out), with its third input tied low when AUTO_SWEEP_EN is undefined.

Verification
REQ-034 Scenario: HOLD_CYC=2, man_req with man_step=2 at edge 10 -> man_gnt and step_en high in cycle 11 with step_amt=2, busy high in cycles 11-13, IDLE at 14, step_cnt=1.
REQ-035 Scenario: man_req and aux_req both held high -> grant order man, aux, man, aux, with issues 1+HOLD_CYC+1 cycles apart.
REQ-036 Scenario: aux_step=0 -> aux_gnt pulses, step_en stays low, step_cnt is unchanged.
REQ-037 Scenario: pause rises during SETTLE -> that step completes; a pending man_req gets no grant until pause falls; the grant follows one cycle after that IDLE edge.
REQ-038 Scenario: rst during SETTLE with man_req held -> all outputs 0 for the next cycle, then man is granted first after reset.
REQ-039 Scenario: AUTO_SWEEP_EN defined, AUTO_DIV=8, no external requests -> step_en with step_amt=1 recurs at a fixed cycle period; step_cnt saturates at 255 after 300 steps.
